// File: rtl/ddr4_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr4_cmd_arbiter
//
// Shares one external DDR4 command/read-data interface between two cores.
// A round-robin arbiter feeds a single registered command slot. An in-order
// read-tag FIFO records which core issued each read, so that returning read
// data can be steered back to that core.
//
// Configuration macro:
//   DDR4_ARB_FIXED_PRIO_EN - when defined, port 0 always wins contention
//                            (port 1 can starve); default is round-robin.
//
// Ports:
//   clk_mem_400mhz, rst_mem_async_n       clock, async active-low reset
//   mN_cmd_valid/ready/addr/wdata/wstrb/we core N command handshake (N=0,1)
//   mN_rdata, mN_rdata_valid               read data returned to core N
//   ext_ddr4_addr/wdata/wstrb              registered external command fields
//   ext_ddr4_cmd_valid/we/ready            external command handshake
//   ext_ddr4_rdata, ext_ddr4_rdata_valid   in-order external read return
//   arb_rd_outstanding                     reads issued but not yet returned
//   arb_err_orphan_rdata                   sticky: read data with no tag
// ---------------------------------------------------------------------------
module ddr4_cmd_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 512,
  parameter int RD_TAG_DEPTH = 8
) (
  input  logic                              clk_mem_400mhz,
  input  logic                              rst_mem_async_n,

  input  logic                              m0_cmd_valid,
  output logic                              m0_cmd_ready,
  input  logic [ADDR_W-1:0]                 m0_cmd_addr,
  input  logic [DATA_W-1:0]                 m0_cmd_wdata,
  input  logic [DATA_W/8-1:0]               m0_cmd_wstrb,
  input  logic                              m0_cmd_we,
  output logic [DATA_W-1:0]                 m0_rdata,
  output logic                              m0_rdata_valid,

  input  logic                              m1_cmd_valid,
  output logic                              m1_cmd_ready,
  input  logic [ADDR_W-1:0]                 m1_cmd_addr,
  input  logic [DATA_W-1:0]                 m1_cmd_wdata,
  input  logic [DATA_W/8-1:0]               m1_cmd_wstrb,
  input  logic                              m1_cmd_we,
  output logic [DATA_W-1:0]                 m1_rdata,
  output logic                              m1_rdata_valid,

  output logic [ADDR_W-1:0]                 ext_ddr4_addr,
  output logic [DATA_W-1:0]                 ext_ddr4_wdata,
  output logic [DATA_W/8-1:0]               ext_ddr4_wstrb,
  output logic                              ext_ddr4_cmd_valid,
  output logic                              ext_ddr4_cmd_we,
  input  logic                              ext_ddr4_cmd_ready,
  input  logic [DATA_W-1:0]                 ext_ddr4_rdata,
  input  logic                              ext_ddr4_rdata_valid,

  output logic [$clog2(RD_TAG_DEPTH+1)-1:0] arb_rd_outstanding,
  output logic                              arb_err_orphan_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(RD_TAG_DEPTH + 1);
  localparam int PTR_W  = $clog2(RD_TAG_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_TAG_DEPTH);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Arbitration and slot control.
  logic              slot_free;
  logic              elig0;
  logic              elig1;
  logic              any_elig;
  port_e             grant_sel;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_we;

  // Read-tag FIFO.
  port_e             tag_mem [RD_TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_empty;
  logic              push;
  logic              pop;
  port_e             head_tag;

  // Read return.
  logic [DATA_W-1:0] rdata_q;

`ifndef DDR4_ARB_FIXED_PRIO_EN
  port_e             last_grant;
`endif

  assign slot_free = !ext_ddr4_cmd_valid || ext_ddr4_cmd_ready;
  assign tag_empty = (tag_count == '0);

  // Reads are held off only by the registered count; a return in the same
  // cycle does not make room until the next cycle.
  assign elig0    = m0_cmd_valid && (m0_cmd_we || (tag_count < FULL_CNT));
  assign elig1    = m1_cmd_valid && (m1_cmd_we || (tag_count < FULL_CNT));
  assign any_elig = elig0 || elig1;

  // NOTE: every signal driven in an always_comb gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_sel = PORT0;
`ifdef DDR4_ARB_FIXED_PRIO_EN
    if (!elig0 && elig1) grant_sel = PORT1;
`else
    if (elig0 && elig1) begin
      grant_sel = (last_grant == PORT1) ? PORT0 : PORT1;
    end else if (elig1) begin
      grant_sel = PORT1;
    end
`endif
  end

  assign m0_cmd_ready = any_elig && (grant_sel == PORT0) && slot_free;
  assign m1_cmd_ready = any_elig && (grant_sel == PORT1) && slot_free;
  assign accept       = m0_cmd_ready || m1_cmd_ready;

  assign sel_addr  = (grant_sel == PORT0) ? m0_cmd_addr  : m1_cmd_addr;
  assign sel_wdata = (grant_sel == PORT0) ? m0_cmd_wdata : m1_cmd_wdata;
  assign sel_wstrb = (grant_sel == PORT0) ? m0_cmd_wstrb : m1_cmd_wstrb;
  assign sel_we    = (grant_sel == PORT0) ? m0_cmd_we    : m1_cmd_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_mem_400mhz or negedge rst_mem_async_n) begin
    if (!rst_mem_async_n) begin
      ext_ddr4_cmd_valid <= 1'b0;
      ext_ddr4_cmd_we    <= 1'b0;
      ext_ddr4_addr      <= '0;
      ext_ddr4_wdata     <= '0;
      ext_ddr4_wstrb     <= '0;
    end else if (accept) begin
      ext_ddr4_cmd_valid <= 1'b1;
      ext_ddr4_cmd_we    <= sel_we;
      ext_ddr4_addr      <= sel_addr;
      ext_ddr4_wdata     <= sel_wdata;
      ext_ddr4_wstrb     <= sel_wstrb;
    end else if (ext_ddr4_cmd_ready) begin
      // Fields are left as-is; only valid drops once the command is taken.
      ext_ddr4_cmd_valid <= 1'b0;
    end
  end

`ifndef DDR4_ARB_FIXED_PRIO_EN
  // Port 1 is "last" out of reset so port 0 wins the first contention.
  always_ff @(posedge clk_mem_400mhz or negedge rst_mem_async_n) begin
    if (!rst_mem_async_n) begin
      last_grant <= PORT1;
    end else if (accept) begin
      last_grant <= grant_sel;
    end
  end
`endif

  // Tag FIFO: a read is tagged when it enters the slot, so the outstanding
  // count includes a read still waiting for the external ready.
  assign push     = accept && !sel_we;
  assign pop      = ext_ddr4_rdata_valid && !tag_empty;
  assign head_tag = tag_mem[rd_ptr];

  // NOTE: the tag storage has no reset; entries are only read between a push
  // and its pop, and the pointers/count that qualify them are reset.
  always_ff @(posedge clk_mem_400mhz) begin
    if (push) tag_mem[wr_ptr] <= grant_sel;
  end

  always_ff @(posedge clk_mem_400mhz or negedge rst_mem_async_n) begin
    if (!rst_mem_async_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  assign arb_rd_outstanding = tag_count;

  // Read return: data always loads (even for an orphan) into one shared
  // register; only the core owning the head tag sees its valid pulse.
  always_ff @(posedge clk_mem_400mhz or negedge rst_mem_async_n) begin
    if (!rst_mem_async_n) begin
      rdata_q              <= '0;
      m0_rdata_valid       <= 1'b0;
      m1_rdata_valid       <= 1'b0;
      arb_err_orphan_rdata <= 1'b0;
    end else begin
      if (ext_ddr4_rdata_valid) rdata_q <= ext_ddr4_rdata;
      m0_rdata_valid <= pop && (head_tag == PORT0);
      m1_rdata_valid <= pop && (head_tag == PORT1);
      if (ext_ddr4_rdata_valid && tag_empty) arb_err_orphan_rdata <= 1'b1;
    end
  end

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_ddr4_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr4_cmd_arbiter
//
// Directed self-checking bench for ddr4_cmd_arbiter. Inputs change and
// outputs are sampled around the falling clock edge; the DUT acts on the
// rising edge.
// ---------------------------------------------------------------------------
module tb_ddr4_cmd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 512;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;

  logic              m0_cmd_valid, m1_cmd_valid;
  logic              m0_cmd_ready, m1_cmd_ready;
  logic [ADDR_W-1:0] m0_cmd_addr, m1_cmd_addr;
  logic [DATA_W-1:0] m0_cmd_wdata, m1_cmd_wdata;
  logic [STRB_W-1:0] m0_cmd_wstrb, m1_cmd_wstrb;
  logic              m0_cmd_we, m1_cmd_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_rdata_valid, m1_rdata_valid;

  logic [ADDR_W-1:0] ext_ddr4_addr;
  logic [DATA_W-1:0] ext_ddr4_wdata;
  logic [STRB_W-1:0] ext_ddr4_wstrb;
  logic              ext_ddr4_cmd_valid;
  logic              ext_ddr4_cmd_we;
  logic              ext_ddr4_cmd_ready;
  logic [DATA_W-1:0] ext_ddr4_rdata;
  logic              ext_ddr4_rdata_valid;
  logic [CNT_W-1:0]  arb_rd_outstanding;
  logic              arb_err_orphan_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr4_cmd_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RD_TAG_DEPTH (DEPTH)
  ) dut (
    .clk_mem_400mhz       (clk),
    .rst_mem_async_n      (rst_n),
    .m0_cmd_valid         (m0_cmd_valid),
    .m0_cmd_ready         (m0_cmd_ready),
    .m0_cmd_addr          (m0_cmd_addr),
    .m0_cmd_wdata         (m0_cmd_wdata),
    .m0_cmd_wstrb         (m0_cmd_wstrb),
    .m0_cmd_we            (m0_cmd_we),
    .m0_rdata             (m0_rdata),
    .m0_rdata_valid       (m0_rdata_valid),
    .m1_cmd_valid         (m1_cmd_valid),
    .m1_cmd_ready         (m1_cmd_ready),
    .m1_cmd_addr          (m1_cmd_addr),
    .m1_cmd_wdata         (m1_cmd_wdata),
    .m1_cmd_wstrb         (m1_cmd_wstrb),
    .m1_cmd_we            (m1_cmd_we),
    .m1_rdata             (m1_rdata),
    .m1_rdata_valid       (m1_rdata_valid),
    .ext_ddr4_addr        (ext_ddr4_addr),
    .ext_ddr4_wdata       (ext_ddr4_wdata),
    .ext_ddr4_wstrb       (ext_ddr4_wstrb),
    .ext_ddr4_cmd_valid   (ext_ddr4_cmd_valid),
    .ext_ddr4_cmd_we      (ext_ddr4_cmd_we),
    .ext_ddr4_cmd_ready   (ext_ddr4_cmd_ready),
    .ext_ddr4_rdata       (ext_ddr4_rdata),
    .ext_ddr4_rdata_valid (ext_ddr4_rdata_valid),
    .arb_rd_outstanding   (arb_rd_outstanding),
    .arb_err_orphan_rdata (arb_err_orphan_rdata)
  );

  // Return to a quiet bus with the external side accepting, and let the
  // output slot drain.
  task automatic go_idle();
    m0_cmd_valid         = 1'b0;
    m1_cmd_valid         = 1'b0;
    ext_ddr4_cmd_ready   = 1'b1;
    ext_ddr4_rdata_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (ext_ddr4_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ext_valid got=%b exp=0", ext_ddr4_cmd_valid); end
    n_checks++; if (ext_ddr4_addr !== '0) begin n_fail++; $display("FAIL reset_ext_addr got=%h exp=0", ext_ddr4_addr); end
    n_checks++; if (arb_rd_outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", arb_rd_outstanding); end
    n_checks++; if (arb_err_orphan_rdata !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got=%b exp=0", arb_err_orphan_rdata); end
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rdata_valid got=%b exp=00", {m0_rdata_valid, m1_rdata_valid}); end
    n_checks++; if (m0_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", m0_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Both cores write continuously; grants alternate starting with port 0.
  task automatic test_contention();
    logic exp0;
    m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m0_cmd_addr = 32'h0000_A000;
    m1_cmd_valid = 1'b1; m1_cmd_we = 1'b1; m1_cmd_addr = 32'h0000_B000;
    m0_cmd_wdata = {16{32'hAAAA_0000}}; m1_cmd_wdata = {16{32'hBBBB_0000}};
    m0_cmd_wstrb = '1; m1_cmd_wstrb = {STRB_W{1'b0}} | 64'h0F;
    ext_ddr4_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef DDR4_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      #1;
      n_checks++; if (m0_cmd_ready !== exp0) begin n_fail++; $display("FAIL contention_m0_ready[%0d] got=%b exp=%b", i, m0_cmd_ready, exp0); end
      n_checks++; if (m1_cmd_ready !== !exp0) begin n_fail++; $display("FAIL contention_m1_ready[%0d] got=%b exp=%b", i, m1_cmd_ready, !exp0); end
      @(negedge clk);
      n_checks++; if (ext_ddr4_addr !== (exp0 ? 32'h0000_A000 : 32'h0000_B000)) begin n_fail++; $display("FAIL contention_addr[%0d] got=%h exp=%h", i, ext_ddr4_addr, exp0 ? 32'h0000_A000 : 32'h0000_B000); end
      n_checks++; if ({ext_ddr4_cmd_valid, ext_ddr4_cmd_we} !== 2'b11) begin n_fail++; $display("FAIL contention_valid_we[%0d] got=%b exp=11", i, {ext_ddr4_cmd_valid, ext_ddr4_cmd_we}); end
    end
    n_checks++; if (ext_ddr4_wstrb !== (exp0 ? {STRB_W{1'b1}} : ({STRB_W{1'b0}} | 64'h0F))) begin n_fail++; $display("FAIL contention_wstrb got=%h", ext_ddr4_wstrb); end
    go_idle();
  endtask

  // Slot holds its command while the external side stalls, then the next
  // command follows with no idle cycle.
  task automatic test_back_pressure();
    ext_ddr4_cmd_ready = 1'b0;
    m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m0_cmd_addr = 32'h0000_1000;
    #1;
    n_checks++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=1", m0_cmd_ready); end
    @(negedge clk);
    m0_cmd_addr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (m0_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", i, m0_cmd_ready); end
      n_checks++; if (ext_ddr4_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid[%0d] got=%b exp=1", i, ext_ddr4_cmd_valid); end
      n_checks++; if (ext_ddr4_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL bp_stall_addr[%0d] got=%h exp=00001000", i, ext_ddr4_addr); end
      @(negedge clk);
    end
    ext_ddr4_cmd_ready = 1'b1;
    #1;
    n_checks++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", m0_cmd_ready); end
    @(negedge clk);
    n_checks++; if (ext_ddr4_addr !== 32'h0000_2000 || ext_ddr4_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_cmd got=%h/%b exp=00002000/1", ext_ddr4_addr, ext_ddr4_cmd_valid); end
    m0_cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ext_ddr4_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got=%b exp=0", ext_ddr4_cmd_valid); end
    go_idle();
  endtask

  // Interleaved reads from both cores; returns steer back in issue order.
  task automatic test_read_routing();
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = {16{32'hD000_0000}};
    d1 = {16{32'hD111_1111}};
    d2 = {16{32'hD222_2222}};
    ext_ddr4_cmd_ready = 1'b1;
    m0_cmd_valid = 1'b1; m0_cmd_we = 1'b0; m0_cmd_addr = 32'h40;
    @(negedge clk);
    m0_cmd_valid = 1'b0;
    m1_cmd_valid = 1'b1; m1_cmd_we = 1'b0; m1_cmd_addr = 32'h80;
    n_checks++; if (ext_ddr4_addr !== 32'h40 || ext_ddr4_cmd_we !== 1'b0) begin n_fail++; $display("FAIL rd_issue0 got=%h/%b exp=40/0", ext_ddr4_addr, ext_ddr4_cmd_we); end
    n_checks++; if (arb_rd_outstanding !== 4'd1) begin n_fail++; $display("FAIL rd_outstanding1 got=%0d exp=1", arb_rd_outstanding); end
    @(negedge clk);
    m1_cmd_valid = 1'b0;
    m0_cmd_valid = 1'b1; m0_cmd_addr = 32'hC0;
    n_checks++; if (ext_ddr4_addr !== 32'h80) begin n_fail++; $display("FAIL rd_issue1 got=%h exp=80", ext_ddr4_addr); end
    @(negedge clk);
    m0_cmd_valid = 1'b0;
    n_checks++; if (ext_ddr4_addr !== 32'hC0) begin n_fail++; $display("FAIL rd_issue2 got=%h exp=c0", ext_ddr4_addr); end
    n_checks++; if (arb_rd_outstanding !== 4'd3) begin n_fail++; $display("FAIL rd_outstanding3 got=%0d exp=3", arb_rd_outstanding); end
    ext_ddr4_rdata_valid = 1'b1; ext_ddr4_rdata = d0;
    @(negedge clk);
    ext_ddr4_rdata = d1;
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b10 || m0_rdata !== d0) begin n_fail++; $display("FAIL rd_ret0 valids=%b exp=10 data=%h", {m0_rdata_valid, m1_rdata_valid}, m0_rdata[31:0]); end
    n_checks++; if (arb_rd_outstanding !== 4'd2) begin n_fail++; $display("FAIL rd_outstanding2 got=%0d exp=2", arb_rd_outstanding); end
    @(negedge clk);
    ext_ddr4_rdata = d2;
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b01 || m1_rdata !== d1) begin n_fail++; $display("FAIL rd_ret1 valids=%b exp=01 data=%h", {m0_rdata_valid, m1_rdata_valid}, m1_rdata[31:0]); end
    @(negedge clk);
    ext_ddr4_rdata_valid = 1'b0;
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b10 || m0_rdata !== d2) begin n_fail++; $display("FAIL rd_ret2 valids=%b exp=10 data=%h", {m0_rdata_valid, m1_rdata_valid}, m0_rdata[31:0]); end
    n_checks++; if (arb_rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL rd_outstanding0 got=%0d exp=0", arb_rd_outstanding); end
    @(negedge clk);
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_width got=%b exp=00", {m0_rdata_valid, m1_rdata_valid}); end
    go_idle();
  endtask

  // Eight reads fill the tag FIFO; further reads stall, writes still flow.
  task automatic test_fifo_full();
    ext_ddr4_cmd_ready = 1'b1;
    m1_cmd_valid = 1'b1; m1_cmd_we = 1'b0; m1_cmd_addr = 32'h300;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (m1_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, m1_cmd_ready); end
      @(negedge clk);
    end
    m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m0_cmd_addr = 32'h5000;
    #1;
    n_checks++; if (m1_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_m1_ready got=%b exp=0", m1_cmd_ready); end
    n_checks++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_m0_write_ready got=%b exp=1", m0_cmd_ready); end
    n_checks++; if (arb_rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL full_outstanding got=%0d exp=8", arb_rd_outstanding); end
    @(negedge clk);
    n_checks++; if (ext_ddr4_addr !== 32'h5000 || ext_ddr4_cmd_we !== 1'b1) begin n_fail++; $display("FAIL full_write_issue got=%h/%b exp=5000/1", ext_ddr4_addr, ext_ddr4_cmd_we); end
    m0_cmd_valid = 1'b0;
    ext_ddr4_rdata_valid = 1'b1; ext_ddr4_rdata = {16{32'hF00D_0000}};
    #1;
    n_checks++; if (m1_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_pop got=%b exp=0", m1_cmd_ready); end
    @(negedge clk);
    ext_ddr4_rdata_valid = 1'b0;
    n_checks++; if (arb_rd_outstanding !== 4'd7 || m1_rdata_valid !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got=%0d/%b exp=7/1", arb_rd_outstanding, m1_rdata_valid); end
    #1;
    n_checks++; if (m1_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_reenable got=%b exp=1", m1_cmd_ready); end
    @(negedge clk);
    m1_cmd_valid = 1'b0;
    n_checks++; if (arb_rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL full_refill got=%0d exp=8", arb_rd_outstanding); end
    ext_ddr4_rdata_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b01) begin n_fail++; $display("FAIL full_drain[%0d] got=%b exp=01", i, {m0_rdata_valid, m1_rdata_valid}); end
    end
    ext_ddr4_rdata_valid = 1'b0;
    n_checks++; if (arb_rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL full_drained got=%0d exp=0", arb_rd_outstanding); end
    go_idle();
  endtask

  // Return data with no outstanding read: no core sees it, flag sticks.
  task automatic test_orphan();
    logic [DATA_W-1:0] dor;
    dor = {16{32'h0BAD_0BAD}};
    ext_ddr4_rdata_valid = 1'b1; ext_ddr4_rdata = dor;
    @(negedge clk);
    ext_ddr4_rdata_valid = 1'b0;
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL orphan_valids got=%b exp=00", {m0_rdata_valid, m1_rdata_valid}); end
    n_checks++; if (arb_err_orphan_rdata !== 1'b1) begin n_fail++; $display("FAIL orphan_flag got=%b exp=1", arb_err_orphan_rdata); end
    n_checks++; if (m1_rdata !== dor) begin n_fail++; $display("FAIL orphan_data_loaded got=%h exp=0bad0bad", m1_rdata[31:0]); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (arb_err_orphan_rdata !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got=%b exp=1", arb_err_orphan_rdata); end
  endtask

  // Reset with reads outstanding and one read stuck in the slot.
  task automatic test_reset_midflight();
    ext_ddr4_cmd_ready = 1'b1;
    m0_cmd_valid = 1'b1; m0_cmd_we = 1'b0; m0_cmd_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    m0_cmd_valid = 1'b0;
    ext_ddr4_cmd_ready = 1'b0;
    n_checks++; if (arb_rd_outstanding !== 4'd3 || ext_ddr4_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%b exp=3/1", arb_rd_outstanding, ext_ddr4_cmd_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ext_ddr4_cmd_valid !== 1'b0 || ext_ddr4_addr !== '0) begin n_fail++; $display("FAIL mid_slot_dropped got=%b/%h exp=0/0", ext_ddr4_cmd_valid, ext_ddr4_addr); end
    n_checks++; if (arb_rd_outstanding !== '0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", arb_rd_outstanding); end
    n_checks++; if (arb_err_orphan_rdata !== 1'b0 || m0_rdata !== '0) begin n_fail++; $display("FAIL mid_flag_data got=%b/%h exp=0/0", arb_err_orphan_rdata, m0_rdata[31:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    ext_ddr4_cmd_ready = 1'b1;
    ext_ddr4_rdata_valid = 1'b1; ext_ddr4_rdata = {16{32'h1234_5678}};
    @(negedge clk);
    ext_ddr4_rdata_valid = 1'b0;
    n_checks++; if (arb_err_orphan_rdata !== 1'b1) begin n_fail++; $display("FAIL mid_orphan got=%b exp=1", arb_err_orphan_rdata); end
    n_checks++; if ({m0_rdata_valid, m1_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_no_valid got=%b exp=00", {m0_rdata_valid, m1_rdata_valid}); end
  endtask

  initial begin
    rst_n                = 1'b0;
    m0_cmd_valid         = 1'b0;
    m1_cmd_valid         = 1'b0;
    m0_cmd_addr          = '0;
    m1_cmd_addr          = '0;
    m0_cmd_wdata         = '0;
    m1_cmd_wdata         = '0;
    m0_cmd_wstrb         = '0;
    m1_cmd_wstrb         = '0;
    m0_cmd_we            = 1'b0;
    m1_cmd_we            = 1'b0;
    ext_ddr4_cmd_ready   = 1'b1;
    ext_ddr4_rdata       = '0;
    ext_ddr4_rdata_valid = 1'b0;
    @(negedge clk);

    test_reset();
    test_contention();
    test_back_pressure();
    test_read_routing();
    test_fifo_full();
    test_orphan();
    test_reset_midflight();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
